// File: rtl/i8088_bus_initiator.sv
// Minimum-mode 8088 bus master: each accepted request becomes one T1-T2-T3-(TW)-T4 cycle.
// rsp_valid is high in T4, four T-states after the accept cycle plus one per TW; requests stall (req_ready=0) in T1..TW.
module i8088_bus_initiator #(
   parameter int WAIT_MAX = 15
) (
   input  logic        I8088_CLK,
   input  logic        CPU_RESET,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic        req_io,
   input  logic [19:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        rsp_timeout,
   output logic        busy,
   output logic [11:0] A19_8_cpu,
   output logic [7:0]  AD8_out_cpu,
   output logic        AD8_enout_cpu,
   input  logic [7:0]  AD8_in_cpu,
   output logic        ALE_cpu,
   output logic        nRD_cpu,
   output logic        nWR_cpu,
   output logic        IO_nM_cpu,
   output logic        DT_nR_cpu,
   output logic        nDEN_cpu,
   input  logic        READY_cpu
);

   localparam int WCW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_T1,
      S_T2,
      S_T3,
      S_TW,
      S_T4
   } state_t;

   state_t           state_q, state_d;
   logic [WCW-1:0]   cnt_q, cnt_d;
   logic             wr_q, wr_d;
   logic [7:0]       wdata_q, wdata_d;
   logic             ale_q, ale_d;
   logic             nrd_q, nrd_d;
   logic             nwr_q, nwr_d;
   logic             nden_q, nden_d;
   logic             io_nm_q, io_nm_d;
   logic             dt_nr_q, dt_nr_d;
   logic             ad_en_q, ad_en_d;
   logic [11:0]      a_hi_q, a_hi_d;
   logic [7:0]       ad_out_q, ad_out_d;
   logic             rsp_vld_q, rsp_vld_d;
   logic             rsp_to_q, rsp_to_d;
   logic [7:0]       rdata_q, rdata_d;
   logic             accept;
   logic             wait_limit;

   assign req_ready  = (state_q == S_IDLE) || (state_q == S_T4);
   assign accept     = req_valid && req_ready;
   assign wait_limit = (WAIT_MAX != 0) && (cnt_q == WCW'(WAIT_MAX));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wr_d      = wr_q;
      wdata_d   = wdata_q;
      ale_d     = ale_q;
      nrd_d     = nrd_q;
      nwr_d     = nwr_q;
      nden_d    = nden_q;
      io_nm_d   = io_nm_q;
      dt_nr_d   = dt_nr_q;
      ad_en_d   = ad_en_q;
      a_hi_d    = a_hi_q;
      ad_out_d  = ad_out_q;
      rsp_vld_d = 1'b0;
      rsp_to_d  = 1'b0;
      rdata_d   = rdata_q;

      case (state_q)
         S_IDLE: begin
            state_d = S_IDLE;
         end
         S_T1: begin
            state_d = S_T2;
            ale_d   = 1'b0;
            nden_d  = 1'b0;
            if (wr_q) begin
               nwr_d    = 1'b0;
               ad_out_d = wdata_q;
               ad_en_d  = 1'b1;
            end else begin
               nrd_d   = 1'b0;
               ad_en_d = 1'b0;
            end
         end
         S_T2: begin
            state_d = S_T3;
         end
         S_T3, S_TW: begin
            if (READY_cpu || wait_limit) begin
               state_d   = S_T4;
               nrd_d     = 1'b1;
               nwr_d     = 1'b1;
               nden_d    = 1'b1;
               rsp_vld_d = 1'b1;
               rsp_to_d  = !READY_cpu;
               if (!wr_q) begin
                  // an aborted read reports the floating-bus value
                  rdata_d = READY_cpu ? AD8_in_cpu : 8'hFF;
               end
            end else begin
               state_d = S_TW;
               cnt_d   = cnt_q + WCW'(1);
            end
         end
         S_T4: begin
            state_d = S_IDLE;
            ad_en_d = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // accept is only possible in IDLE/T4 and overrides their next state
      if (accept) begin
         state_d  = S_T1;
         cnt_d    = '0;
         wr_d     = req_write;
         wdata_d  = req_wdata;
         ale_d    = 1'b1;
         a_hi_d   = req_io ? {4'h0, req_addr[15:8]} : req_addr[19:8];
         ad_out_d = req_addr[7:0];
         ad_en_d  = 1'b1;
         io_nm_d  = req_io;
         dt_nr_d  = req_write;
      end
   end

   always_ff @(posedge I8088_CLK or posedge CPU_RESET) begin
      if (CPU_RESET) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         wr_q      <= 1'b0;
         wdata_q   <= 8'h00;
         ale_q     <= 1'b0;
         nrd_q     <= 1'b1;
         nwr_q     <= 1'b1;
         nden_q    <= 1'b1;
         io_nm_q   <= 1'b0;
         dt_nr_q   <= 1'b0;
         ad_en_q   <= 1'b0;
         a_hi_q    <= 12'h000;
         ad_out_q  <= 8'h00;
         rsp_vld_q <= 1'b0;
         rsp_to_q  <= 1'b0;
         rdata_q   <= 8'hFF;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wr_q      <= wr_d;
         wdata_q   <= wdata_d;
         ale_q     <= ale_d;
         nrd_q     <= nrd_d;
         nwr_q     <= nwr_d;
         nden_q    <= nden_d;
         io_nm_q   <= io_nm_d;
         dt_nr_q   <= dt_nr_d;
         ad_en_q   <= ad_en_d;
         a_hi_q    <= a_hi_d;
         ad_out_q  <= ad_out_d;
         rsp_vld_q <= rsp_vld_d;
         rsp_to_q  <= rsp_to_d;
         rdata_q   <= rdata_d;
      end
   end

   assign busy          = (state_q != S_IDLE);
   assign rsp_valid     = rsp_vld_q;
   assign rsp_timeout   = rsp_to_q;
   assign rsp_rdata     = rdata_q;
   assign A19_8_cpu     = a_hi_q;
   assign AD8_out_cpu   = ad_out_q;
   assign AD8_enout_cpu = ad_en_q;
   assign ALE_cpu       = ale_q;
   assign nRD_cpu       = nrd_q;
   assign nWR_cpu       = nwr_q;
   assign IO_nM_cpu     = io_nm_q;
   assign DT_nR_cpu     = dt_nr_q;
   assign nDEN_cpu      = nden_q;

endmodule

// File: tb/tb_i8088_bus_initiator.sv
// Randomized scoreboard bench for i8088_bus_initiator with a bench-side 8088 target.
module tb_i8088_bus_initiator;
   localparam int WMAX = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        req_valid, req_ready, req_write, req_io;
   logic [19:0] req_addr;
   logic [7:0]  req_wdata;
   logic        rsp_valid, rsp_timeout, busy;
   logic [7:0]  rsp_rdata;
   logic [11:0] A19_8_cpu;
   logic [7:0]  AD8_out_cpu, AD8_in_cpu;
   logic        AD8_enout_cpu, ALE_cpu, nRD_cpu, nWR_cpu, IO_nM_cpu, DT_nR_cpu, nDEN_cpu, READY_cpu;

   logic        b_valid, b_ready_o, b_write, b_io;
   logic [19:0] b_addr;
   logic [7:0]  b_wdata, b_rdata, b_ad_out, b_ad_in;
   logic        b_rsp_valid, b_timeout, b_busy, b_en, b_ale, b_nrd, b_nwr, b_ionm, b_dtnr, b_nden, b_ready;
   logic [11:0] b_ahi;

   i8088_bus_initiator #(.WAIT_MAX(WMAX)) u0 (
      .I8088_CLK(clk), .CPU_RESET(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_io(req_io),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout), .busy(busy),
      .A19_8_cpu(A19_8_cpu), .AD8_out_cpu(AD8_out_cpu), .AD8_enout_cpu(AD8_enout_cpu),
      .AD8_in_cpu(AD8_in_cpu), .ALE_cpu(ALE_cpu), .nRD_cpu(nRD_cpu), .nWR_cpu(nWR_cpu),
      .IO_nM_cpu(IO_nM_cpu), .DT_nR_cpu(DT_nR_cpu), .nDEN_cpu(nDEN_cpu), .READY_cpu(READY_cpu)
   );

   i8088_bus_initiator #(.WAIT_MAX(0)) u1 (
      .I8088_CLK(clk), .CPU_RESET(rst),
      .req_valid(b_valid), .req_ready(b_ready_o), .req_write(b_write), .req_io(b_io),
      .req_addr(b_addr), .req_wdata(b_wdata),
      .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .rsp_timeout(b_timeout), .busy(b_busy),
      .A19_8_cpu(b_ahi), .AD8_out_cpu(b_ad_out), .AD8_enout_cpu(b_en),
      .AD8_in_cpu(b_ad_in), .ALE_cpu(b_ale), .nRD_cpu(b_nrd), .nWR_cpu(b_nwr),
      .IO_nM_cpu(b_ionm), .DT_nR_cpu(b_dtnr), .nDEN_cpu(b_nden), .READY_cpu(b_ready)
   );

   typedef struct {
      bit        wr;
      bit        io;
      bit [19:0] addr;
      bit [7:0]  wdata;
      bit [7:0]  rdata;
      int        w;
   } txn_t;

   typedef struct {
      bit [7:0] rdata;
      bit       to;
      int       lat;
      int       acc;
   } rsp_t;

   txn_t mon_q[$];
   txn_t tgt_q[$];
   rsp_t sb_q[$];
   int   rsp_log[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   logic [7:0] model_rdata = 8'hFF;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int taken(input int w);
      return (WMAX != 0 && w > WMAX) ? WMAX : w;
   endfunction

   // Present a request at a negedge, hold it until accepted, and record what must come back.
   task automatic issue(input bit wr, input bit io, input bit [19:0] addr, input bit [7:0] wd,
                        input bit [7:0] rd, input int w);
      txn_t t;
      rsp_t r;
      int   n;
      bit   timed;
      req_write = wr; req_io = io; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         chk("accept_wait", req_ready, 1);
         req_valid = 1'b0;
         return;
      end
      t.wr = wr; t.io = io; t.addr = addr; t.wdata = wd; t.rdata = rd; t.w = w;
      timed = (WMAX != 0) && (w > WMAX);
      if (!wr) model_rdata = timed ? 8'hFF : rd;
      r.rdata = model_rdata;
      r.to    = timed;
      r.lat   = 4 + taken(w);
      r.acc   = cyc;
      mon_q.push_back(t);
      tgt_q.push_back(t);
      sb_q.push_back(r);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      req_valid = 1'b0;
      repeat (n) begin
         req_write = 1'($urandom); req_io = 1'($urandom);
         req_addr = 20'($urandom); req_wdata = 8'($urandom);
         @(negedge clk);
      end
   endtask

   // Target: READY low for the planned number of sampled edges, then data with READY high.
   bit   r_active = 0, r_seen = 0;
   int   r_rem = 0;
   bit [7:0] r_rd = 0;
   always @(negedge clk) begin
      txn_t t;
      if (rst) begin
         r_active = 0;
         READY_cpu = 1'b1;
      end else if (ALE_cpu) begin
         if (tgt_q.size() > 0) begin
            t = tgt_q.pop_front();
            r_rem = t.w;
            r_rd  = t.rdata;
         end else begin
            r_rem = 0;
            r_rd  = 8'h00;
         end
         r_active = 1; r_seen = 0;
         READY_cpu = 1'($urandom); AD8_in_cpu = 8'($urandom);
      end else if (r_active && (!nRD_cpu || !nWR_cpu)) begin
         if (!r_seen) begin
            r_seen = 1;
            READY_cpu = 1'($urandom); AD8_in_cpu = 8'($urandom);
         end else if (r_rem == 0) begin
            READY_cpu = 1'b1; AD8_in_cpu = r_rd;
         end else begin
            READY_cpu = 1'b0; AD8_in_cpu = 8'($urandom);
            r_rem--;
         end
      end else begin
         r_active = 0;
         READY_cpu = 1'($urandom); AD8_in_cpu = 8'($urandom);
      end
   end

   // Monitor: bus-phase checks per cycle and scoreboard pop on each response.
   bit   m_active = 0;
   int   m_strb = 0;
   txn_t m_cur;
   always @(negedge clk) begin
      rsp_t r;
      logic [11:0] ea;
      if (rst) begin
         m_active = 0;
      end else begin
         if (ALE_cpu) begin
            if (mon_q.size() == 0) begin
               chk("ale_unexpected", ALE_cpu, 0);
            end else begin
               m_cur = mon_q.pop_front();
               m_active = 1; m_strb = 0;
               ea = m_cur.io ? {4'h0, m_cur.addr[15:8]} : m_cur.addr[19:8];
               chk("t1_a19_8", A19_8_cpu, ea);
               chk("t1_ad", AD8_out_cpu, m_cur.addr[7:0]);
               chk("t1_enout", AD8_enout_cpu, 1);
               chk("t1_io_nm", IO_nM_cpu, m_cur.io);
               chk("t1_dt_nr", DT_nR_cpu, m_cur.wr);
               chk("t1_strobes", {nRD_cpu, nWR_cpu, nDEN_cpu}, 3'b111);
            end
         end else if (m_active && (!nRD_cpu || !nWR_cpu)) begin
            m_strb++;
            chk("strobe_sel", {nRD_cpu, nWR_cpu, nDEN_cpu}, m_cur.wr ? 3'b100 : 3'b010);
            chk("data_enout", AD8_enout_cpu, m_cur.wr);
            if (m_cur.wr) chk("write_data", AD8_out_cpu, m_cur.wdata);
         end
         if (rsp_valid) begin
            if (sb_q.size() == 0) begin
               chk("rsp_unexpected", rsp_valid, 0);
            end else begin
               r = sb_q.pop_front();
               rsp_log.push_back(cyc);
               chk("rsp_rdata", rsp_rdata, r.rdata);
               chk("rsp_timeout", rsp_timeout, r.to);
               chk("rsp_latency", cyc - r.acc, r.lat);
               chk("t4_busy", busy, 1);
               if (m_active) begin
                  chk("strobe_len", m_strb, 2 + taken(m_cur.w));
                  chk("t4_strobes", {nRD_cpu, nWR_cpu, nDEN_cpu}, 3'b111);
                  chk("t4_enout", AD8_enout_cpu, m_cur.wr);
                  if (m_cur.wr) chk("t4_data_hold", AD8_out_cpu, m_cur.wdata);
                  m_active = 0;
               end
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, low;
      req_valid = 0; req_write = 0; req_io = 0; req_addr = '0; req_wdata = '0;
      b_valid = 0; b_write = 0; b_io = 0; b_addr = '0; b_wdata = '0; b_ready = 1; b_ad_in = 8'h00;
      READY_cpu = 1; AD8_in_cpu = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_ale", ALE_cpu, 0);
      chk("rst_strobes", {nRD_cpu, nWR_cpu, nDEN_cpu}, 3'b111);
      chk("rst_io_nm", IO_nM_cpu, 0);
      chk("rst_dt_nr", DT_nR_cpu, 0);
      chk("rst_enout", AD8_enout_cpu, 0);
      chk("rst_a19_8", A19_8_cpu, 0);
      chk("rst_ad", AD8_out_cpu, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_timeout", rsp_timeout, 0);
      chk("rst_rdata", rsp_rdata, 8'hFF);
      chk("rst_busy", busy, 0);
      chk("rst_req_ready", req_ready, 1);
      #2 rst = 0;
      @(negedge clk);

      // reset mid-T2 of a write drops the cycle
      issue(1, 0, 20'h12345, 8'hA5, 8'h00, 0);
      idle(0);
      @(negedge clk);
      chk("pre_rst_nwr", nWR_cpu, 0);
      #2 rst = 1;
      #1;
      chk("midrst_nwr", nWR_cpu, 1);
      chk("midrst_enout", AD8_enout_cpu, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_ready", req_ready, 1);
      chk("midrst_rsp", rsp_valid, 0);
      sb_q.delete(); mon_q.delete(); tgt_q.delete();
      model_rdata = 8'hFF;
      @(negedge clk);
      #2 rst = 0;
      @(negedge clk);
      idle(5);

      // memory read at the reset vector
      issue(0, 0, 20'hFFFF0, 8'h00, 8'hEA, 0);
      idle(8);
      // I/O write with two wait states
      issue(1, 1, 20'h003F8, 8'h5A, 8'h00, 2);
      idle(10);
      // back-to-back reads
      issue(0, 0, 20'h01234, 8'h00, 8'h11, 0);
      issue(0, 0, 20'h05678, 8'h00, 8'h22, 0);
      idle(10);
      if (rsp_log.size() >= 2) chk("b2b_gap", rsp_log[rsp_log.size()-1] - rsp_log[rsp_log.size()-2], 4);
      else chk("b2b_count", rsp_log.size(), 2);
      // timeout read, then a normal read
      issue(0, 0, 20'hABCDE, 8'h00, 8'h77, 10);
      idle(2);
      issue(0, 0, 20'h00042, 8'h00, 8'h42, 1);
      idle(10);

      for (int i = 0; i < 80; i++) begin
         issue(1'($urandom), 1'($urandom), 20'($urandom), 8'($urandom), 8'($urandom),
               $urandom_range(0, 5));
         if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 3));
      end
      idle(0);
      n = 0;
      while (sb_q.size() > 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain", sb_q.size(), 0);

      // WAIT_MAX = 0: forty waits complete normally
      b_write = 0; b_io = 0; b_addr = 20'h4A5C3; b_ready = 0; b_valid = 1;
      @(negedge clk);
      b_valid = 0;
      chk("w0_t1_ale", b_ale, 1);
      n = 0; low = 0;
      while (!b_rsp_valid && n < 200) begin
         if (!b_nrd) low++;
         if (low == 42) begin
            b_ready = 1; b_ad_in = 8'h3C;
         end else begin
            b_ad_in = 8'($urandom);
         end
         @(negedge clk);
         n++;
      end
      chk("w0_rsp_valid", b_rsp_valid, 1);
      chk("w0_timeout", b_timeout, 0);
      chk("w0_rdata", b_rdata, 8'h3C);
      chk("w0_nrd_len", low, 42);
      chk("w0_latency", n, 43);
      @(negedge clk);
      chk("w0_pulse", b_rsp_valid, 0);
      chk("w0_idle", b_busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
